// File: rtl/morph_op_pkg.sv
// Shared types and min/max helpers for the 3x3 morphological filter.
package morph_op_pkg;

  localparam int PIX_W = 8;
  localparam int ROW_W = 16;

  typedef logic [PIX_W-1:0] pixel_t;

  localparam bit OP_ERODE  = 1'b0;
  localparam bit OP_DILATE = 1'b1;

  // Value that never wins the reduction: all ones for erosion, zero for dilation.
  function automatic pixel_t neutral(input bit op);
    pixel_t n;
    n = (op == OP_ERODE) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
    return n;
  endfunction

  function automatic pixel_t sel(input pixel_t a, input pixel_t b, input bit op);
    pixel_t r;
    if (op == OP_ERODE) r = (a < b) ? a : b;
    else                r = (a > b) ? a : b;
    return r;
  endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// One video line of pixel storage; the read returns the old word in the same cycle it is overwritten.
module morph_line_buffer #(
  parameter int DEPTH = 1280,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/morph_op_top.sv
// Streaming 3x3 erosion/dilation: two line buffers, a 3-column window and a two-stage min/max tree.
module morph_op_top
  import morph_op_pkg::*;
#(
  parameter int VIDEO_WIDTH      = 1280,
  parameter int VIDEO_DATA_WIDTH = PIX_W,
  parameter int OP               = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_active,
  input  logic                        in_hsync,
  input  logic                        in_vsync,
  input  logic [VIDEO_DATA_WIDTH-1:0] in_data,
  output logic                        out_active,
  output logic                        out_hsync,
  output logic                        out_vsync,
  output logic [VIDEO_DATA_WIDTH-1:0] out_data
);

  localparam int     CW   = $clog2(VIDEO_WIDTH);
  localparam bit     OP_B = (OP != 0);
  localparam pixel_t N    = neutral(OP_B);

  logic [CW-1:0]    col;
  logic [ROW_W-1:0] row;
  logic [2:0]       act_d, hs_d, vs_d;
  logic             vs_rise, act_fall;
  pixel_t           lb0_q, lb1_q;
  pixel_t           cur [3];
  pixel_t           w1  [3];
  pixel_t           w2  [3];
  pixel_t           rsel[3];
  pixel_t           res;

  assign vs_rise  = in_vsync & ~vs_d[0];
  assign act_fall = ~in_active & act_d[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_d <= '0;
      hs_d  <= '0;
      vs_d  <= '0;
    end else begin
      act_d <= {act_d[1:0], in_active};
      hs_d  <= {hs_d[1:0], in_hsync};
      vs_d  <= {vs_d[1:0], in_vsync};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
    end else if (!in_active) begin
      col <= '0;
    end else if (col != CW'(VIDEO_WIDTH - 1)) begin
      col <= col + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
    end else if (vs_rise) begin
      row <= '0;
    end else if (act_fall && row != {ROW_W{1'b1}}) begin
      row <= row + ROW_W'(1);
    end
  end

  // LB1 shifts into LB0 at the same address, so LB0 always trails LB1 by one line.
  morph_line_buffer #(.DEPTH(VIDEO_WIDTH), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (in_active),
    .addr  (col),
    .wdata (in_data),
    .rdata (lb1_q)
  );

  morph_line_buffer #(.DEPTH(VIDEO_WIDTH), .WIDTH(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (in_active),
    .addr  (col),
    .wdata (lb1_q),
    .rdata (lb0_q)
  );

  // Newest window column; blanking and output line 0 feed the neutral value.
  always_comb begin
    cur[0] = N;
    cur[1] = N;
    cur[2] = N;
    if (in_active && row != '0) begin
      cur[0] = (row == ROW_W'(1)) ? N : lb0_q;
      cur[1] = lb1_q;
      cur[2] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        w1[i]   <= N;
        w2[i]   <= N;
        rsel[i] <= N;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        w1[i]   <= cur[i];
        w2[i]   <= w1[i];
        rsel[i] <= sel(sel(w2[i], w1[i], OP_B), cur[i], OP_B);
      end
    end
  end

  assign res = sel(sel(rsel[0], rsel[1], OP_B), rsel[2], OP_B);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
    end else begin
      out_data <= act_d[1] ? res : '0;
    end
  end

  assign out_active = act_d[2];
  assign out_hsync  = hs_d[2];
  assign out_vsync  = vs_d[2];

endmodule

// File: tb/tb_morph_op_top.sv
// Directed bench: erode and dilate instances share one stream; outputs compared against hand-derived results.
module tb_morph_op_top;

  localparam int W = 8;

  typedef struct {
    logic [2:0] sync;
    logic [7:0] exp_e;
    logic [7:0] exp_d;
  } ent_t;

  logic       clk;
  logic       rst;
  logic       in_active, in_hsync, in_vsync;
  logic [7:0] in_data;
  logic       oa_e, oh_e, ov_e, oa_d, oh_d, ov_d;
  logic [7:0] od_e, od_d;

  int   n_chk;
  int   n_fail;
  int   brow;
  ent_t hist[3];

  morph_op_top #(.VIDEO_WIDTH(W), .VIDEO_DATA_WIDTH(8), .OP(0)) u_ero (
    .clk(clk), .rst(rst), .in_active(in_active), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_data(in_data), .out_active(oa_e), .out_hsync(oh_e), .out_vsync(ov_e), .out_data(od_e)
  );

  morph_op_top #(.VIDEO_WIDTH(W), .VIDEO_DATA_WIDTH(8), .OP(1)) u_dil (
    .clk(clk), .rst(rst), .in_active(in_active), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_data(in_data), .out_active(oa_d), .out_hsync(oh_d), .out_vsync(ov_d), .out_data(od_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    logic [7:0] p;
    case (pat)
      0:       p = 8'h80;
      1:       p = c[0] ? 8'hFF : 8'h00;
      default: p = (r == 2 && c == 3) ? 8'hFF : 8'h00;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] exp_px(input int op, input int pat, input int r, input int c);
    logic [7:0] e;
    if (r == 0)        e = (op != 0) ? 8'h00 : 8'hFF;
    else if (pat == 0) e = 8'h80;
    else if (pat == 1) e = (op != 0) ? 8'hFF : 8'h00;
    else               e = (op == 1 && r >= 2 && r <= 4 && c >= 2 && c <= 4) ? 8'hFF : 8'h00;
    return e;
  endfunction

  // Check outputs for the inputs applied three clocks ago, then apply the next inputs.
  task automatic step(input logic r, input logic a, input logic h, input logic v,
                      input logic [7:0] d, input logic [7:0] ee, input logic [7:0] ed);
    @(negedge clk);
    chk("sync_ero", {29'd0, oa_e, oh_e, ov_e}, {29'd0, hist[2].sync});
    chk("sync_dil", {29'd0, oa_d, oh_d, ov_d}, {29'd0, hist[2].sync});
    chk("data_ero", {24'd0, od_e}, {24'd0, hist[2].exp_e});
    chk("data_dil", {24'd0, od_d}, {24'd0, hist[2].exp_d});
    hist[2] = hist[1];
    hist[1] = hist[0];
    if (!r) begin
      for (int i = 0; i < 3; i++) hist[i] = '{3'b000, 8'h00, 8'h00};
    end else begin
      hist[0] = '{{a, h, v}, a ? ee : 8'h00, a ? ed : 8'h00};
    end
    rst       = r;
    in_active = a;
    in_hsync  = h;
    in_vsync  = v;
    in_data   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic send_line(input int pat);
    for (int c = 0; c < W; c++)
      step(1'b1, 1'b1, 1'b1, 1'b0, pix(pat, brow, c), exp_px(0, pat, brow, c), exp_px(1, pat, brow, c));
    idle(4);
    brow++;
  endtask

  task automatic send_frame(input int pat, input int nlines);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    idle(3);
    brow = 0;
    for (int l = 0; l < nlines; l++) send_line(pat);
  endtask

  task automatic reset_pulse(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 8'h00, 8'h00);
    brow = 0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    brow      = 0;
    rst       = 1'b0;
    in_active = 1'b0;
    in_hsync  = 1'b0;
    in_vsync  = 1'b0;
    in_data   = 8'h00;
    for (int i = 0; i < 3; i++) hist[i] = '{3'b000, 8'h00, 8'h00};

    reset_pulse(5);
    idle(3);

    send_frame(0, 6);
    send_frame(1, 6);
    send_frame(2, 6);

    // Reset partway through line 3; the next line restarts as output line 0.
    send_frame(0, 3);
    for (int c = 0; c < 4; c++)
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'h80, exp_px(0, 0, brow, c), exp_px(1, 0, brow, c));
    reset_pulse(3);
    idle(3);
    send_line(0);
    send_line(0);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
